// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the stream reader: FSM state encoding and FIFO sizing.
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/spram_stream_reader_if.sv
// Output stream bundle of the SPRAM stream reader.
interface spram_stream_reader_if #(
  parameter int W_DATA = 32
);
  // A beat transfers on a rising edge where m_valid && m_ready are both 1; once
  // m_valid is raised, m_data and m_last hold until that beat is accepted.
  logic              m_valid;
  logic [W_DATA-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry FIFO; a push and a pop in the same cycle leave the occupancy unchanged.
module stream_fifo2
  import cnn_accel_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [W-1:0]          head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [W-1:0]          r_mem [FIFO_DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full      = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  // When full, a push is only taken if the head is leaving in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rptr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
        2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spram_stream_reader.sv
// Reads num_words consecutive words from an external single-port RAM starting at
// base_addr and streams them out in order through a 2-entry FIFO.
module spram_stream_reader
  import cnn_accel_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4,
  parameter int W_LEN  = W_WORD + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [W_WORD-1:0] base_addr,
  input  logic [W_LEN-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [W_WORD-1:0] ram_addr,
  input  logic [W_DATA-1:0] ram_dout,
  spram_stream_reader_if.master m,
  output state_t            dbg_state
);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [W_WORD-1:0]   r_addr;
  logic [W_LEN-1:0]    r_num;
  logic [W_LEN-1:0]    r_issued;
  logic [W_LEN-1:0]    r_beats;
  logic                r_pend_valid;
  logic                r_pend_last;

  logic                  w_full;
  logic                  w_empty;
  logic [W_DATA:0]       w_head;
  logic [FIFO_CNT_W-1:0] w_count;
  logic                  w_pop;
  logic [2:0]            w_load;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_final_beat;

  assign w_pop        = !w_empty && m.m_ready;
  // Entries that will be held once this cycle's pop and the pending read settle;
  // counting the pop lets reads stream at one per cycle without overflowing.
  assign w_load       = 3'(w_count) + 3'(r_pend_valid) - 3'(w_pop);
  assign w_issue      = (r_state == ST_READ) && (r_issued != r_num) &&
                        (w_load < 3'(FIFO_DEPTH)) && !(w_full && !w_pop);
  assign w_issue_last = (r_issued == r_num - W_LEN'(1));
  assign w_final_beat = (r_beats == r_num - W_LEN'(1));

  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_en    = w_issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = r_addr;
  assign dbg_state = r_state;

  assign m.m_valid = !w_empty;
  assign m.m_data  = w_head[W_DATA-1:0];
  assign m.m_last  = w_head[W_DATA] && !w_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_num    <= '0;
      r_issued <= '0;
      r_beats  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr   <= base_addr;
            r_num    <= num_words;
            r_issued <= '0;
            r_beats  <= '0;
            r_busy   <= 1'b1;
            if (num_words == '0) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr   <= r_addr + W_WORD'(1);
            r_issued <= r_issued + W_LEN'(1);
          end
          if (w_pop) begin
            r_beats <= r_beats + W_LEN'(1);
            if (w_final_beat) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM data appears one cycle after ram_en; the last-beat tag travels alongside.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend_last  <= 1'b0;
    end else begin
      r_pend_valid <= w_issue;
      r_pend_last  <= w_issue && w_issue_last;
    end
  end

  stream_fifo2 #(
    .W (W_DATA + 1)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (r_pend_valid),
    .push_data ({r_pend_last, ram_dout}),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head),
    .count     (w_count)
  );

endmodule

// File: tb/tb_spram_stream_reader.sv
// Directed bench for spram_stream_reader with an external RAM model and a beat monitor.
module tb_spram_stream_reader;
  import cnn_accel_pkg::*;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  num_words;
  logic        busy;
  logic        done;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [31:0] ram_dout;
  state_t      dbg_state;

  spram_stream_reader_if #(.W_DATA(32)) mif ();

  spram_stream_reader #(
    .W_DATA (32),
    .W_WORD (4),
    .W_LEN  (5)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m         (mif.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external single-port RAM
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h1111_1111;
    ram_dout = '0;
  end
  always @(posedge clk) if (ram_en && !ram_we) ram_dout <= mem[ram_addr];

  // scoreboard state
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] data_q[$];
  logic        last_q[$];
  int          beat_cyc_q[$];
  logic [3:0]  addr_q[$];
  int          done_cnt, done_cyc, first_valid_cyc, stall_err, credit_err;
  int          outstanding = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    exp_q.delete(); data_q.delete(); last_q.delete(); beat_cyc_q.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; stall_err = 0; credit_err = 0;
  endtask

  // monitor: samples on the falling edge
  always @(negedge clk) begin
    logic acc;
    cyc++;
    acc = mif.m_valid && mif.m_ready;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!rstn) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (mif.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (!mif.m_valid || mif.m_data !== prev_data || mif.m_last !== prev_last))
        stall_err++;
      if (ram_en && ((outstanding - int'(acc)) >= 2)) credit_err++;
      if (ram_en) addr_q.push_back(ram_addr);
      if (acc) begin
        data_q.push_back(mif.m_data);
        last_q.push_back(mif.m_last);
        beat_cyc_q.push_back(cyc);
      end
      outstanding = outstanding + int'(ram_en) - int'(acc);
      prev_stall  = mif.m_valid && !mif.m_ready;
      prev_data   = mif.m_data;
      prev_last   = mif.m_last;
    end
  end

  // stimulus table
  typedef struct {
    logic [3:0]  base;
    logic [4:0]  num;
    int          mode;        // 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
    int          restart_at;  // cycle offset of a stray start pulse, 0 for none
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  function automatic logic ready_bit(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_transfer(input int id, input vec_t v);
    int          t;
    int          start_cyc;
    logic [3:0]  a;
    clear_mon();
    for (int k = 0; k < int'(v.num); k++) begin
      a = v.base + 4'(k);
      exp_q.push_back({8{a}});
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; num_words = v.num;
    mif.m_ready = ready_bit(v.mode, 0);
    start_cyc = cyc + 1;
    t = 1;
    do begin
      @(posedge clk); #1;
      start       = (t == v.restart_at);
      base_addr   = 4'($urandom_range(0, 15));
      num_words   = 5'($urandom_range(0, 31));
      mif.m_ready = ready_bit(v.mode, t);
      t++;
    end while (done_cnt == 0 && t < 200);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check($sformatf("v%0d_done_count", id), 64'(done_cnt), 64'd1);
    check($sformatf("v%0d_beat_count", id), 64'(data_q.size()), 64'(v.num));
    check($sformatf("v%0d_read_count", id), 64'(addr_q.size()), 64'(v.num));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < data_q.size()) begin
        check($sformatf("v%0d_data%0d", id, k), 64'(data_q[k]), 64'(exp_q[k]));
        check($sformatf("v%0d_last%0d", id, k), 64'(last_q[k]), 64'(k == int'(v.num) - 1));
      end
      if (k < addr_q.size()) begin
        a = v.base + 4'(k);
        check($sformatf("v%0d_addr%0d", id, k), 64'(addr_q[k]), 64'(a));
      end
    end
    if (v.num == 0) begin
      check($sformatf("v%0d_no_valid", id), 64'(first_valid_cyc), 64'(-1));
      check($sformatf("v%0d_done_cycle", id), 64'(done_cyc), 64'(start_cyc + 1));
    end else if (data_q.size() == int'(v.num)) begin
      check($sformatf("v%0d_first_data", id), 64'(data_q[0]), 64'(v.exp_first));
      check($sformatf("v%0d_last_data", id), 64'(data_q[data_q.size()-1]), 64'(v.exp_last));
      check($sformatf("v%0d_done_cycle", id), 64'(done_cyc), 64'(beat_cyc_q[beat_cyc_q.size()-1] + 1));
      if (v.mode == 0) begin
        // first beat two cycles after the edge that accepts start
        check($sformatf("v%0d_first_valid_cycle", id), 64'(first_valid_cyc), 64'(start_cyc + 3));
        check($sformatf("v%0d_back_to_back", id),
              64'(beat_cyc_q[beat_cyc_q.size()-1] - beat_cyc_q[0]), 64'(int'(v.num) - 1));
      end
    end
    check($sformatf("v%0d_stall_stable", id), 64'(stall_err), 64'd0);
    check($sformatf("v%0d_read_credit", id), 64'(credit_err), 64'd0);
    check($sformatf("v%0d_idle_state", id), 64'(dbg_state), 64'(ST_IDLE));
    check($sformatf("v%0d_busy_low", id), 64'(busy), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     64'(busy),         64'd0);
    check({tag, "_done"},     64'(done),         64'd0);
    check({tag, "_ram_en"},   64'(ram_en),       64'd0);
    check({tag, "_ram_we"},   64'(ram_we),       64'd0);
    check({tag, "_ram_addr"}, 64'(ram_addr),     64'd0);
    check({tag, "_m_valid"},  64'(mif.m_valid),  64'd0);
    check({tag, "_m_last"},   64'(mif.m_last),   64'd0);
    check({tag, "_m_data"},   64'(mif.m_data),   64'd0);
    check({tag, "_state"},    64'(dbg_state),    64'(ST_IDLE));
  endtask

  initial begin
    int t;
    vecs[0] = '{base: 4'd2,  num: 5'd5,  mode: 0, restart_at: 0, exp_first: 32'h2222_2222, exp_last: 32'h6666_6666};
    vecs[1] = '{base: 4'd14, num: 5'd4,  mode: 0, restart_at: 0, exp_first: 32'hEEEE_EEEE, exp_last: 32'h1111_1111};
    vecs[2] = '{base: 4'd2,  num: 5'd5,  mode: 1, restart_at: 0, exp_first: 32'h2222_2222, exp_last: 32'h6666_6666};
    vecs[3] = '{base: 4'd0,  num: 5'd0,  mode: 0, restart_at: 0, exp_first: 32'h0,         exp_last: 32'h0};
    vecs[4] = '{base: 4'd9,  num: 5'd1,  mode: 0, restart_at: 0, exp_first: 32'h9999_9999, exp_last: 32'h9999_9999};
    vecs[5] = '{base: 4'd2,  num: 5'd5,  mode: 0, restart_at: 3, exp_first: 32'h2222_2222, exp_last: 32'h6666_6666};
    vecs[6] = '{base: 4'd3,  num: 5'd31, mode: 2, restart_at: 0, exp_first: 32'h3333_3333, exp_last: 32'h1111_1111};

    rstn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; mif.m_ready = 1'b0;
    clear_mon();
    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_transfer(i, vecs[i]);

    // abort a 5-word transfer right after its second beat
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd2; num_words = 5'd5; mif.m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (data_q.size() < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_two_beats", 64'(data_q.size()), 64'd2);
    rstn = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    rstn = 1'b1;
    run_transfer(7, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spram_stream_reader.md
SPRAM_STREAM_READER -- requirements
Module: spram_stream_reader

Interface
REQ-001 Parameter W_DATA, default 32: RAM word and stream data width in bits.
REQ-002 Parameter W_WORD, default 4: RAM address width in bits.
REQ-003 Parameter W_LEN, default W_WORD+1: width of the transfer length field.
REQ-004 clk  input  1  single clock; all logic samples on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 base_addr  input  W_WORD  first RAM word address; captured when start is accepted.
REQ-008 num_words  input  W_LEN  number of words to read; captured when start is accepted.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse when the transfer completes.
REQ-011 ram_en  output  1  RAM enable.
REQ-012 ram_we  output  1  RAM write enable; tied to 0.
REQ-013 ram_addr  output  W_WORD  RAM word address.
REQ-014 ram_dout  input  W_DATA  RAM read data; valid one cycle after a cycle with ram_en=1 and ram_we=0.
REQ-015 m_valid  output  1  stream data valid.
REQ-016 m_data  output  W_DATA  stream data.
REQ-017 m_last  output  1  marks the final beat of a transfer.
REQ-018 m_ready  input  1  downstream accepts a beat when m_valid and m_ready are both 1.

Function
REQ-019 The state machine SHALL have three states: IDLE, READ and FINISH.
- IDLE -> READ on start when num_words != 0.
- IDLE -> FINISH on start when num_words == 0.
- READ -> FINISH when the last beat is accepted.
- FINISH -> IDLE unconditionally after one cycle.
REQ-020 In FINISH, done SHALL be 1 for exactly that one cycle; no beat SHALL be emitted for num_words == 0.
REQ-021 Read k (k = 0..num_words-1) SHALL use ram_addr = base_addr + k, truncated to W_WORD bits (wrap-around modulo 2^W_WORD).
REQ-022 ram_en SHALL be 1 only in READ, only while issued reads < num_words, and only while (FIFO occupancy + reads in flight) < 2.
REQ-023 Returned data SHALL be written into a 2-entry FIFO one cycle after its ram_en cycle; m_valid, m_data and m_last SHALL come from the FIFO head.
REQ-024 Beats SHALL appear in address order with no loss or duplication under any m_ready pattern.
REQ-025 Back-to-back operation: with m_ready held at 1, beats SHALL be sustained at one per cycle, with the first m_valid two cycles after start.
REQ-026 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-027 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-028 m_last SHALL be 1 only on beat num_words-1.
REQ-029 start in any state other than IDLE SHALL be ignored; base_addr and num_words SHALL be ignored outside start acceptance.
REQ-030 The beat counter and the issue counter SHALL be W_LEN bits wide; num_words up to 2^W_LEN-1 SHALL be supported, with addresses wrapping.

Reset
REQ-031 rstn low SHALL immediately force:
- state = IDLE;
- busy, done, ram_en, m_valid, m_last = 0;
- ram_addr = 0;
- m_data = 0;
- FIFO emptied and all counters cleared.
REQ-032 rstn asserted mid-transfer SHALL abort the transfer with no done pulse; after release, the block SHALL accept a new start.

Structure
REQ-033 State encoding (IDLE/READ/FINISH) and the FIFO depth constant (2) SHALL live in a shared package, cnn_accel_pkg.
REQ-034 The 2-entry FIFO SHALL be a separate sub-module, stream_fifo2, with push/pop/full/empty ports.
REQ-035 No RAM instance SHALL reside inside this block; it connects externally to a single-port RAM.

Verification
REQ-036 RAM preloaded with mem[i] = i*0x11111111; base_addr=2, num_words=5, m_ready=1 -> beats 0x22222222..0x66666666 on consecutive cycles, m_last on the 5th beat, done one cycle after it.
REQ-037 W_WORD=4, base_addr=14, num_words=4 -> addresses 14, 15, 0, 1 in that order.
REQ-038 Same transfer as REQ-036 with m_ready toggling 1,0,0,1,0,... -> identical beat sequence, data stable while stalled, ram_en never issued with 2 entries occupied or pending.
REQ-039 num_words=0 -> done pulses one cycle after start; m_valid and ram_en stay 0.
REQ-040 rstn pulled low after the 2nd beat of a 5-word transfer -> all outputs 0 and no done pulse; a new transfer then completes correctly.
REQ-041 start re-pulsed during READ -> ignored; the original transfer completes unchanged.
